ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  Parametrised AHB-Lite slave: word-organised register memory with byte strobes, programmable
//  wait states and two-cycle ERROR response. Next-generation responder behind the AHB decoder;
//  the bench drives it through ahb_slave_if. Adds depth, wait-state, protection and error modes.
// PARAMETERS
//  ADDR_WIDTH   32  address bus width (bits)
//  DATA_WIDTH   32  data bus width; 32 or 64
//  DEPTH        16  number of DATA_WIDTH words; byte span = DEPTH*DATA_WIDTH/8
//  WAIT_CYCLES  0   wait states inserted per OKAY NONSEQ/SEQ transfer (0..15)
//  PROT_EN      0   1: non-privileged access (prot[1]=0) to word 0 returns ERROR
// PORTS
//  clk          in   1             bus clock
//  rstn         in   1             asynchronous active-low reset
//  sel          in   1             slave select from decoder
//  trans        in   2             00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  addr         in   ADDR_WIDTH    byte address (address phase)
//  write        in   1             1 write, 0 read
//  size         in   3             transfer size, log2 bytes
//  prot         in   4             protection attributes
//  strb         in   DATA_WIDTH/8  write byte strobes (data phase)
//  wdata        in   DATA_WIDTH    write data (data phase)
//  ready_in     in   1             bus ready (previous transfer complete)
//  ready        out  1             this slave's ready
//  slave_error  out  1             response: 1 ERROR, 0 OKAY
//  rdata        out  DATA_WIDTH    read data, valid when ready=1 and slave_error=0
// BEHAVIOUR
//  Reset: ready=1, slave_error=0, rdata=0, state IDLE, all memory words 0. Reset mid-transfer
//   aborts it immediately; no memory write occurs.
//  Accept: address phase sampled at posedge when sel & ready_in & trans[1]; latch addr,write,
//   size,prot. sel & ready_in with trans=IDLE/BUSY: zero-wait OKAY, no access.
//  Error check at accept (any true -> ERROR): addr >= byte span; size > log2(DATA_WIDTH/8);
//   addr not aligned to size; PROT_EN & prot[1]=0 & word index 0.
//  FSM: IDLE -> WAIT (OKAY, WAIT_CYCLES>0) | DATA (OKAY, WAIT_CYCLES=0) | ERR1 (error).
//   WAIT: ready=0, count down WAIT_CYCLES; last wait cycle -> DATA.
//   DATA: ready=1, slave_error=0; transfer completes; if new accept same edge -> next state
//    per its checks, else IDLE.
//   ERR1: ready=0, slave_error=1 -> ERR2. ERR2: ready=1, slave_error=1; completes like DATA.
//  Latency: OKAY = WAIT_CYCLES+1 data-phase cycles; ERROR = 2 cycles, never wait-stated.
//  Write: at completing edge of DATA, bytes with strb[i]=1 written; strb ignored outside
//   size-selected lanes. ERROR transfers never write.
//  Read: rdata = full word at latched index, combinational during data phase; in IDLE/ERR
//   rdata holds 0. Write immediately followed by read of same word returns new data.
//  Pipelining: next address phase overlaps current data phase; accepted only on cycle with
//   ready=1 (ready_in). BUSY during a burst: zero-wait OKAY, counters untouched.
//  Word index = addr[log2(byte span)-1 : log2(DATA_WIDTH/8)].
// TESTING
//  1 Reset: rstn=0 -> ready=1, slave_error=0, rdata=0; read any word after reset -> 0.
//  2 WAIT=0: write 0xDEADBEEF @0x4 strb=F, back-to-back read @0x4 -> rdata 0xDEADBEEF, ready=1 both
//    cycles; write 0x11 strb=0001 then read -> 0xDEADBE11.
//  3 WAIT=3: read @0x8 -> ready low exactly 3 cycles, high 4th with data; pipelined next accept ok.
//  4 Errors: addr 0x40 (DEPTH=16) -> ready=0/err=1 then ready=1/err=1; addr 0x2 size=2 -> ERROR;
//    memory unchanged after errored write.
//  5 PROT_EN=1: write word 0 prot=0000 -> ERROR; prot=0010 -> OKAY and written.
//  6 Reset asserted during WAIT of a write -> ready=1 next, target word reads 0.

Source files
------------

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave-side bus bundle: address/data phase signals from the master side
// and the slave's response.
interface ahb_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    sel;
  logic [1:0]              trans;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [2:0]              size;
  logic [3:0]              prot;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ready_in;
  logic                    ready;
  logic                    slave_error;
  logic [DATA_WIDTH-1:0]   rdata;

  // Handshake: an address phase (sel & trans[1]) is taken at a rising edge only while
  // ready_in is high; that transfer's data phase then runs until a cycle with ready=1,
  // and the master must hold its next address phase stable while ready is low.
  modport master (
    output sel, trans, addr, write, size, prot, strb, wdata, ready_in,
    input  ready, slave_error, rdata
  );
  modport slave (
    input  sel, trans, addr, write, size, prot, strb, wdata, ready_in,
    output ready, slave_error, rdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with a word-organised register memory, byte strobes, programmable
// wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int PROT_EN     = 0
) (
  input  logic        clk,
  input  logic        rstn,
  ahb_slave_if.slave  bus,
  output logic [2:0]  dbg_state
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int LOG2NB = $clog2(NB);
  localparam int IDXW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * NB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [IDXW-1:0]       idx_q;
  logic [LOG2NB-1:0]     off_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  misaligned;
  logic                  bad;
  logic [NB-1:0]         lane_en;
  logic                  unused_bits;

  assign unused_bits = ^{bus.trans[0], bus.prot[3:2], bus.prot[0]};

  // Own ready gates acceptance so a held address is never taken during wait/ERR1 cycles.
  assign accept = bus.sel & bus.ready_in & bus.trans[1] & bus.ready;

  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < LOG2NB; i++)
      if (3'(i) < bus.size && bus.addr[i]) misaligned = 1'b1;
  end

  assign bad = (bus.addr >= SPAN) || (bus.size > 3'(LOG2NB)) || misaligned ||
               ((PROT_EN != 0) && !bus.prot[1] &&
                (bus.addr[IDXW+LOG2NB-1:LOG2NB] == '0));

  // Only lanes covered by the latched size/offset may be written, whatever strb says.
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NB; i++)
      if (i >= int'(off_q) && i < int'(off_q) + (1 << int'(size_q)))
        lane_en[i] = bus.strb[i];
  end

  assign bus.rdata = (state == S_DATA) ? mem[idx_q] : '0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      bus.ready       <= 1'b1;
      bus.slave_error <= 1'b0;
      wait_cnt        <= '0;
      idx_q           <= '0;
      off_q           <= '0;
      size_q          <= '0;
      write_q         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == S_DATA && write_q)
        for (int b = 0; b < NB; b++)
          if (lane_en[b]) mem[idx_q][b*8 +: 8] <= bus.wdata[b*8 +: 8];

      case (state)
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= S_DATA;
            bus.ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          bus.ready <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present ready=1 and may take the next address phase.
          if (accept) begin
            idx_q   <= bus.addr[IDXW+LOG2NB-1:LOG2NB];
            off_q   <= bus.addr[LOG2NB-1:0];
            size_q  <= bus.size;
            write_q <= bus.write;
            if (bad) begin
              state           <= S_ERR1;
              bus.ready       <= 1'b0;
              bus.slave_error <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              state           <= S_WAIT;
              wait_cnt        <= 4'(WAIT_CYCLES - 1);
              bus.ready       <= 1'b0;
              bus.slave_error <= 1'b0;
            end else begin
              state           <= S_DATA;
              bus.ready       <= 1'b1;
              bus.slave_error <= 1'b0;
            end
          end else begin
            state           <= S_IDLE;
            bus.ready       <= 1'b1;
            bus.slave_error <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (no waits, 3 waits, protection on) driven
// from a transfer list, checked every cycle against a transfer-level memory model.
module tb_ahb_slave_mem;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beat_no = 0;
  int low_cnt = 0;
  int cur = 0;

  logic        m_sel = 1'b0;
  logic [1:0]  m_trans = 2'b00;
  logic [31:0] m_addr = '0;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = 3'd2;
  logic [3:0]  m_prot = 4'b0010;
  logic [3:0]  m_strb = 4'h0;
  logic [31:0] m_wdata = '0;

  logic [2:0] dbg_unused0, dbg_unused1, dbg_unused2;
  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;

  ahb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  ahb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
  ahb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  assign if0.sel = m_sel && (cur == 0);
  assign if1.sel = m_sel && (cur == 1);
  assign if2.sel = m_sel && (cur == 2);
  assign if0.trans = m_trans;  assign if1.trans = m_trans;  assign if2.trans = m_trans;
  assign if0.addr  = m_addr;   assign if1.addr  = m_addr;   assign if2.addr  = m_addr;
  assign if0.write = m_write;  assign if1.write = m_write;  assign if2.write = m_write;
  assign if0.size  = m_size;   assign if1.size  = m_size;   assign if2.size  = m_size;
  assign if0.prot  = m_prot;   assign if1.prot  = m_prot;   assign if2.prot  = m_prot;
  assign if0.strb  = m_strb;   assign if1.strb  = m_strb;   assign if2.strb  = m_strb;
  assign if0.wdata = m_wdata;  assign if1.wdata = m_wdata;  assign if2.wdata = m_wdata;
  assign if0.ready_in = if0.ready;
  assign if1.ready_in = if1.ready;
  assign if2.ready_in = if2.ready;

  ahb_slave_mem #(.WAIT_CYCLES(0), .PROT_EN(0)) u0 (
    .clk(clk), .rstn(rstn), .bus(if0.slave), .dbg_state(dbg_unused0));
  ahb_slave_mem #(.WAIT_CYCLES(3), .PROT_EN(0)) u1 (
    .clk(clk), .rstn(rstn), .bus(if1.slave), .dbg_state(dbg_unused1));
  ahb_slave_mem #(.WAIT_CYCLES(0), .PROT_EN(1)) u2 (
    .clk(clk), .rstn(rstn), .bus(if2.slave), .dbg_state(dbg_unused2));

  always_comb begin
    cur_ready = if0.ready;
    cur_err   = if0.slave_error;
    cur_rdata = if0.rdata;
    if (cur == 1) begin
      cur_ready = if1.ready;
      cur_err   = if1.slave_error;
      cur_rdata = if1.rdata;
    end else if (cur == 2) begin
      cur_ready = if2.ready;
      cur_err   = if2.slave_error;
      cur_rdata = if2.rdata;
    end
  end

  // ---------------- model ----------------
  int wait_of [3] = '{0, 3, 0};
  bit prot_of [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mm [3][16];

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } op_t;
  op_t ops[$];

  // {check_rdata, ready, slave_error, rdata} for each cycle of a run
  logic [34:0] exp_q[$];

  function automatic bit is_bad(int k, op_t o);
    int nbytes;
    if (o.addr >= 32'd64) return 1'b1;
    if (o.size > 3'd2) return 1'b1;
    nbytes = 1 << o.size;
    if ((o.addr % nbytes) != 0) return 1'b1;
    if (prot_of[k] && !o.prot[1] && (o.addr / 4) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(int k, op_t o);
    int off, nbytes, idx;
    off = int'(o.addr % 4);
    nbytes = 1 << o.size;
    idx = int'(o.addr / 4);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + nbytes && o.strb[b])
        mm[k][idx][8*b +: 8] = o.wdata[8*b +: 8];
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) mm[k][i] = '0;
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [3:0] pr, input logic [3:0] sb,
                     input logic [31:0] wd);
    op_t o;
    o.trans = tr; o.wr = wr; o.addr = a; o.size = sz;
    o.prot = pr; o.strb = sb; o.wdata = wd;
    ops.push_back(o);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge with the selected slave idle.
  task automatic run_ops(input int k);
    bit d_act;
    bit d_err;
    bit fin;
    int d_left;
    int guard;
    op_t d;
    cur = k;
    d_act = 1'b0;
    d_err = 1'b0;
    d_left = 0;
    guard = 0;
    d = '0;
    while ((ops.size() > 0 || d_act) && guard < 2000) begin
      if (!d_act) begin
        fin = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0});
      end else begin
        fin = (d_left == 1);
        if (d_err)      exp_q.push_back({1'b1, fin, 1'b1, 32'h0});
        else if (!fin)  exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h0});
        else            exp_q.push_back({!d.wr, 1'b1, 1'b0, mm[k][d.addr / 4]});
        m_strb  = d.strb;
        m_wdata = d.wdata;
      end
      if (ops.size() > 0) begin
        m_sel   = 1'b1;
        m_trans = ops[0].trans;
        m_addr  = ops[0].addr;
        m_write = ops[0].wr;
        m_size  = ops[0].size;
        m_prot  = ops[0].prot;
      end else begin
        m_sel   = 1'b0;
        m_trans = 2'b00;
      end
      @(posedge clk);
      #1;
      guard++;
      if (d_act && fin && !d_err && d.wr) model_write(k, d);
      if (d_act) begin
        d_left--;
        if (fin) d_act = 1'b0;
      end
      if (fin && ops.size() > 0) begin
        op_t o;
        o = ops.pop_front();
        if (o.trans[1]) begin
          d = o;
          d_act = 1'b1;
          d_err = is_bad(k, o);
          d_left = d_err ? 2 : wait_of[k] + 1;
        end
      end
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL run_ops budget: got %0d cycles, required < 2000", guard);
    end
    m_sel = 1'b0;
    m_trans = 2'b00;
  endtask

  // ---------------- compare ----------------
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        beat_no++;
        if (cur == 1 && cur_ready === 1'b0) low_cnt++;
        if (cur_ready !== e[33] || cur_err !== e[32] || (e[34] && cur_rdata !== e[31:0])) begin
          errors++;
          $display("FAIL resp beat %0d dut %0d: ready=%b err=%b rdata=%h, required ready=%b err=%b rdata=%h",
                   beat_no, cur, cur_ready, cur_err, cur_rdata, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset ready u0", {31'b0, if0.ready}, 32'h1);
    check("reset err u0", {31'b0, if0.slave_error}, 32'h0);
    check("reset rdata u0", if0.rdata, 32'h0);
    check("reset ready u1", {31'b0, if1.ready}, 32'h1);
    check("reset ready u2", {31'b0, if2.ready}, 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // reads after reset, then writes/reads with strobes and narrow sizes, no wait states
    add(2'b10, 1'b0, 32'h00, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h3C, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h04, 3'd2, 4'h2, 4'hF, 32'hDEADBEEF);
    add(2'b10, 1'b0, 32'h04, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h04, 3'd2, 4'h2, 4'h1, 32'h00000011);
    add(2'b10, 1'b0, 32'h04, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b00, 1'b0, 32'h00, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h06, 3'd0, 4'h2, 4'hF, 32'hAABBCCDD);
    add(2'b11, 1'b0, 32'h04, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h0A, 3'd1, 4'h2, 4'hF, 32'h12345678);
    add(2'b01, 1'b0, 32'h0C, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b11, 1'b0, 32'h08, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(0);
    check("model byte write", mm[0][1], 32'hDEBBBE11);
    check("model half write", mm[0][2], 32'h12340000);

    // error responses; errored write must leave memory untouched
    add(2'b10, 1'b0, 32'h40, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h02, 3'd2, 4'h2, 4'hF, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 32'h06, 3'd2, 4'h2, 4'hF, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 32'h05, 3'd1, 4'h2, 4'hF, 32'hFFFFFFFF);
    add(2'b10, 1'b0, 32'h08, 3'd3, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h04, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(0);
    check("model after errors", mm[0][1], 32'hDEBBBE11);

    // three wait states: single read, then pipelined write/read/read and an error
    low_cnt = 0;
    add(2'b10, 1'b0, 32'h08, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(1);
    check("wait low cycles single", low_cnt, 32'd3);
    low_cnt = 0;
    add(2'b10, 1'b1, 32'h08, 3'd2, 4'h2, 4'hF, 32'h0BADF00D);
    add(2'b11, 1'b0, 32'h08, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b11, 1'b0, 32'h0C, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h44, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(1);
    check("wait low cycles pipelined", low_cnt, 32'd10);

    // protection on word 0
    add(2'b10, 1'b1, 32'h00, 3'd2, 4'h0, 4'hF, 32'h55555555);
    add(2'b10, 1'b1, 32'h00, 3'd2, 4'h2, 4'hF, 32'hCAFEF00D);
    add(2'b10, 1'b0, 32'h00, 3'd2, 4'h2, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h00, 3'd2, 4'h0, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h04, 3'd2, 4'h0, 4'hF, 32'h01020304);
    add(2'b10, 1'b0, 32'h04, 3'd2, 4'h0, 4'h0, 32'h0);
    run_ops(2);
    check("model prot word0", mm[2][0], 32'hCAFEF00D);

    // reset during the wait states of a write
    cur = 1;
    m_sel = 1'b1; m_trans = 2'b10; m_addr = 32'h0C; m_write = 1'b1;
    m_size = 3'd2; m_prot = 4'h2;
    @(posedge clk);
    #1;
    m_sel = 1'b0; m_trans = 2'b00; m_strb = 4'hF; m_wdata = 32'hA5A5A5A5;
    check("wait ready low", {31'b0, cur_ready}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort ready", {31'b0, cur_ready}, 32'h1);
    check("abort err", {31'b0, cur_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    add(2'b10, 1'b0, 32'h0C, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(1);
    add(2'b10, 1'b0, 32'h04, 3'd2, 4'h2, 4'h0, 32'h0);
    run_ops(0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
